if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_if.sv | 25 ++
 rtl/if_fetch.sv | 97 +++++++++
 tb/tb_if_fetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Allows at most one outstanding request; the response is returned on imem_rvalid.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one imem request at a time, holds the returned word for
// IF/ID until consumed, and handles EX redirects, including discarding in-flight responses.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    if_fetch_if.master        imem,
    input  logic              StallF,
    input  logic              PCSrcE,
    input  logic [31:0]       PCTargetE,
    output logic [31:0]       inst,
    output logic [31:0]       pc,
    output logic              fetch_valid
);

    typedef enum logic [1:0] {StReq, StWait, StHold, StKill} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        outstanding;
    logic [31:0] redirect_pc;

    // Low target bits are forced to zero, so they are intentionally unused.
    logic unused_tgt;
    assign unused_tgt  = ^PCTargetE[1:0];
    assign redirect_pc = {PCTargetE[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            inst_buf_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
        end
    end

    always_comb begin
        outstanding = 1'b0;
        unique case (state_q)
            StReq:   outstanding = imem.imem_gnt;
            StWait:  outstanding = !imem.imem_rvalid;
            StKill:  outstanding = !imem.imem_rvalid;
            default: outstanding = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_buf_d = inst_buf_q;

        if (PCSrcE) begin
            // Redirect wins over stall and consume; an in-flight response must be drained.
            pc_d    = redirect_pc;
            state_d = outstanding ? StKill : StReq;
        end else begin
            unique case (state_q)
                StReq: begin
                    if (imem.imem_gnt) state_d = StWait;
                end
                StWait: begin
                    if (imem.imem_rvalid) begin
                        inst_buf_d = imem.imem_rdata;
                        state_d    = StHold;
                    end
                end
                StHold: begin
                    if (!StallF) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = StReq;
                    end
                end
                StKill: begin
                    if (imem.imem_rvalid) state_d = StReq;
                end
                default: state_d = StReq;
            endcase
        end
    end

    always_comb begin
        imem.imem_req  = (state_q == StReq);
        imem.imem_addr = pc_q;
        fetch_valid    = (state_q == StHold);
        inst           = fetch_valid ? inst_buf_q : 32'h0;
        pc             = fetch_valid ? pc_q : 32'h0;
    end

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        imem.imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a per-cycle vector table of bus/hazard inputs and expected
// Moore outputs, plus hand-written reset sequences.
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_valid;

    int checks = 0;
    int errors = 0;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus.master),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .inst        (inst),
        .pc          (pc),
        .fetch_valid (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic stall, input logic pcsrc, input logic [31:0] tgt,
                       input logic gnt, input logic rvalid, input logic [31:0] rdata,
                       input logic e_req, input logic [31:0] e_addr, input logic e_fv,
                       input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.stall = stall; v.pcsrc = pcsrc; v.tgt = tgt; v.gnt = gnt;
        v.rvalid = rvalid; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
        v.e_fv = e_fv; v.e_inst = e_inst; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_fv, input logic [31:0] e_inst,
                                 input logic [31:0] e_pc);
        check({tag, " imem_req"}, {31'b0, bus.imem_req}, {31'b0, e_req});
        check({tag, " imem_addr"}, bus.imem_addr, e_addr);
        check({tag, " fetch_valid"}, {31'b0, fetch_valid}, {31'b0, e_fv});
        check({tag, " inst"}, inst, e_inst);
        check({tag, " pc"}, pc, e_pc);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;

        // stall pcsrc tgt gnt rvalid rdata | req addr fv inst pc
        add(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 1, 32'hA000_0000, 0, 32'h0000_0000, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0000, 1, 32'hA000_0000, 32'h0);
        add(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 1, 32'hA000_0004, 0, 32'h0000_0004, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0004, 1, 32'hA000_0004, 32'h4);
        add(1, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0000_0004, 1, 32'hA000_0004, 32'h4);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0004, 1, 32'hA000_0004, 32'h4);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0004, 1, 32'hA000_0004, 32'h4);
        add(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0008, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 1, 32'hA000_0008, 0, 32'h0000_0008, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0008, 1, 32'hA000_0008, 32'h8);
        add(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_000C, 0, 32'h0,         32'h0);
        // Redirect in WAIT: response still in flight -> killed.
        add(0, 1, 32'h0000_0103, 0, 0, 32'h0,         0, 32'h0000_000C, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 32'h0000_0100, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 1, 32'hB000_0100, 0, 32'h0000_0100, 0, 32'h0,         32'h0);
        // Redirect together with stall in HOLD.
        add(1, 1, 32'h0000_0200, 0, 0, 32'h0,         0, 32'h0000_0100, 1, 32'hB000_0100, 32'h100);
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0200, 0, 32'h0,         32'h0);
        add(1, 0, 32'h0,         0, 1, 32'h1111_1111, 1, 32'h0000_0200, 0, 32'h0,         32'h0);
        // Redirect in REQ with grant -> KILL; second redirect in KILL only moves pc.
        add(0, 1, 32'hFFFF_FFFF, 1, 0, 32'h0,         1, 32'h0000_0200, 0, 32'h0,         32'h0);
        add(1, 1, 32'hFFFF_FFFE, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 1, 32'h1234_5678, 0, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 1, 32'hC000_0000, 0, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'hC000_0000, 32'hFFFF_FFFC);
        // pc wrapped to zero after consume.
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         32'h0);

        #1;
        check_outputs("reset", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            StallF = vecs[i].stall;
            PCSrcE = vecs[i].pcsrc;
            PCTargetE = vecs[i].tgt;
            bus.imem_gnt = vecs[i].gnt;
            bus.imem_rvalid = vecs[i].rvalid;
            bus.imem_rdata = vecs[i].rdata;
            #2;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_fv,
                          vecs[i].e_inst, vecs[i].e_pc);
        end

        // Reset asserted mid-WAIT, stale rvalid right after release must be ignored.
        @(negedge clk);
        StallF = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h40;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
        @(negedge clk);
        PCSrcE = 1'b0; bus.imem_gnt = 1'b1;
        #2;
        check_outputs("pre_rst", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        #2;
        check("in_wait imem_req", {31'b0, bus.imem_req}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        #2;
        check_outputs("stale_rvalid", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #2;
        check_outputs("still_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
